ram_burst_master: RTL and testbench

- Initiator that drives a ram64x8-style synchronous RAM port (en/we/addr/datain/dataout) on behalf of a client.
- Accepts single or burst read/write commands over a valid/ready command channel.
- Streams write data in and read data out over valid/ready channels.
- Sequences RAM accesses with incrementing, wrapping addresses; sits between a client (test sequencer or CPU-side logic) and the RAM.

---
 rtl/ram_pkg.sv | 15 +
 rtl/ram_burst_master.sv | 125 ++++++++++++
 tb/tb_ram_burst_master.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared types and default widths for the ram64x8 port and its burst master.
package ram_pkg;

   localparam int unsigned RAM_ADDR_W = 6;
   localparam int unsigned RAM_DATA_W = 8;
   localparam int unsigned RAM_LEN_W  = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR       = 2'd1,
      RD_ISSUE = 2'd2,
      RD_DATA  = 2'd3
   } state_t;

endpackage

// File: rtl/ram_burst_master.sv
// Burst initiator for a ram64x8-style synchronous RAM: single/burst reads and
// writes with incrementing, wrapping addresses over valid/ready channels.
module ram_burst_master
   import ram_pkg::*;
#(
   parameter int unsigned ADDR_W = RAM_ADDR_W,
   parameter int unsigned DATA_W = RAM_DATA_W,
   parameter int unsigned LEN_W  = RAM_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_datain,
   input  logic [DATA_W-1:0] mem_dataout
);

   state_t            state, state_d;
   logic [ADDR_W-1:0] cur_addr, cur_addr_d;
   logic [LEN_W-1:0]  beats_left, beats_left_d;
   logic              is_write, is_write_d;

   // State and burst bookkeeping registers; reset aborts any burst in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_addr   <= '0;
         beats_left <= '0;
         is_write   <= 1'b0;
      end else begin
         state      <= state_d;
         cur_addr   <= cur_addr_d;
         beats_left <= beats_left_d;
         is_write   <= is_write_d;
      end
   end

   // Next-state and combinational outputs; the RAM port is driven straight from state.
   always_comb begin
      state_d      = state;
      cur_addr_d   = cur_addr;
      beats_left_d = beats_left;
      is_write_d   = is_write;
      cmd_ready    = 1'b0;
      wr_ready     = 1'b0;
      rd_valid     = 1'b0;
      rd_data      = '0;
      rd_last      = 1'b0;
      busy         = 1'b1;
      mem_en       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_datain   = '0;

      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               cur_addr_d   = cmd_addr;
               beats_left_d = cmd_len;
               is_write_d   = cmd_we;
               state_d      = cmd_we ? WR : RD_ISSUE;
            end
         end

         WR: begin
            wr_ready   = 1'b1;
            mem_en     = wr_valid;
            mem_we     = wr_valid & is_write;
            mem_addr   = cur_addr;
            mem_datain = wr_data;
            if (wr_valid) begin
               cur_addr_d = cur_addr + ADDR_W'(1);
               if (beats_left == '0) begin
                  state_d = IDLE;
               end else begin
                  beats_left_d = beats_left - LEN_W'(1);
               end
            end
         end

         RD_ISSUE: begin
            mem_en   = 1'b1;
            mem_addr = cur_addr;
            state_d  = RD_DATA;
         end

         RD_DATA: begin
            // Enable stays high so the RAM keeps presenting the captured word.
            mem_en   = 1'b1;
            mem_addr = cur_addr;
            rd_valid = 1'b1;
            rd_data  = mem_dataout;
            rd_last  = (beats_left == '0);
            if (rd_ready) begin
               if (beats_left == '0) begin
                  state_d = IDLE;
               end else begin
                  cur_addr_d   = cur_addr + ADDR_W'(1);
                  beats_left_d = beats_left - LEN_W'(1);
                  state_d      = RD_ISSUE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_burst_master.sv
// Bench for ram_burst_master: behavioural ram64x8 plus an array reference model.
module tb_ram_burst_master;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       cmd_valid, cmd_ready, cmd_we;
   logic [5:0] cmd_addr;
   logic [3:0] cmd_len;
   logic       wr_valid, wr_ready;
   logic [7:0] wr_data;
   logic       rd_valid, rd_ready, rd_last, busy;
   logic [7:0] rd_data;
   logic       mem_en, mem_we;
   logic [5:0] mem_addr;
   logic [7:0] mem_datain, mem_dataout;

   int errors = 0;
   int checks = 0;

   // Behavioural RAM: word registered on enabled edges, output forced to 0 when disabled.
   logic [7:0] ram [64];
   logic [7:0] ram_q;
   int         nwrites = 0;

   // Reference contents, updated from the spec's rules for every accepted write beat.
   logic [7:0] ref_mem [64];

   typedef struct {
      bit         we;
      logic [5:0] a;
      logic [3:0] l;
      logic [7:0] d0;
      logic [7:0] dinc;
      int         pct;
      logic [5:0] exp_last;
   } vec_t;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            ram[mem_addr] <= mem_datain;
            nwrites <= nwrites + 1;
         end
         ram_q <= ram[mem_addr];
      end
   end
   assign mem_dataout = mem_en ? ram_q : 8'h00;

   ram_burst_master dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
      .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_datain(mem_datain), .mem_dataout(mem_dataout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_cmd_ready"}, cmd_ready, 1);
      chk({tag, "_wr_ready"}, wr_ready, 0);
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_rd_last"}, rd_last, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_mem_en"}, mem_en, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_datain"}, mem_datain, 0);
   endtask

   // Offer one command from IDLE; returns one cycle after the accepting edge.
   task automatic send_cmd(input bit we, input logic [5:0] a, input logic [3:0] l);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
      @(negedge clk);
      chk("cmd_ready_idle", cmd_ready, 1);
      chk("mem_en_idle", mem_en, 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_addr = 6'($urandom); cmd_len = 4'($urandom); cmd_we = 1'($urandom);
   endtask

   task automatic wr_burst(input logic [5:0] a, input logic [3:0] l, input logic [7:0] d0,
                           input logic [7:0] dinc, input int gap, input logic [15:0] pat,
                           input bit use_pat, input logic [5:0] exp_last);
      int i, cyc, n0;
      logic [5:0] addr, last;
      logic [7:0] d;
      bit v;
      n0 = nwrites;
      send_cmd(1'b1, a, l);
      i = 0; cyc = 0; addr = a; last = a;
      while (i <= int'(l) && cyc < 200) begin
         if (use_pat) v = (cyc < 16) ? pat[cyc] : 1'b1;
         else         v = ($urandom_range(99) >= gap);
         d = d0 + 8'(i) * dinc;
         wr_valid = v; wr_data = v ? d : 8'($urandom);
         @(negedge clk);
         chk("wr_ready", wr_ready, 1);
         chk("wr_cmd_ready_low", cmd_ready, 0);
         chk("wr_mem_en", mem_en, v);
         if (v) begin
            chk("wr_mem_we", mem_we, 1);
            chk("wr_mem_addr", mem_addr, addr);
            chk("wr_mem_datain", mem_datain, d);
         end
         @(posedge clk); #1;
         if (v) begin
            ref_mem[addr] = d; last = addr; addr = addr + 6'd1; i++;
         end
         cyc++;
      end
      if (cyc >= 200) chk("wr_timeout", 1, 0);
      wr_valid = 1'b0;
      @(negedge clk);
      chk("wr_done_busy", busy, 0);
      chk("wr_done_mem_en", mem_en, 0);
      chk("wr_last_addr", last, exp_last);
      chk("wr_count", nwrites - n0, int'(l) + 1);
      @(posedge clk); #1;
   endtask

   task automatic rd_burst(input logic [5:0] a, input logic [3:0] l, input int stall,
                           input int hold0, input logic [5:0] exp_last);
      int i, cyc, hold;
      logic [5:0] addr, last;
      bit r, exp_valid;
      send_cmd(1'b0, a, l);
      // First cycle after acceptance is the address issue; data shows one cycle later.
      @(negedge clk);
      chk("rd_issue_valid", rd_valid, 0);
      chk("rd_issue_en", mem_en, 1);
      chk("rd_issue_we", mem_we, 0);
      chk("rd_issue_addr", mem_addr, a);
      @(posedge clk); #1;
      i = 0; cyc = 0; addr = a; last = a; hold = hold0; exp_valid = 1'b1;
      while (i <= int'(l) && cyc < 300) begin
         if (exp_valid && i == 0 && hold > 0) begin
            r = 1'b0; hold--;
         end else begin
            r = ($urandom_range(99) >= stall);
         end
         rd_ready = r;
         @(negedge clk);
         chk("rd_valid", rd_valid, exp_valid);
         chk("rd_cmd_ready_low", cmd_ready, 0);
         chk("rd_mem_en", mem_en, 1);
         chk("rd_mem_we", mem_we, 0);
         chk("rd_mem_addr", mem_addr, addr);
         if (exp_valid) begin
            chk("rd_data", rd_data, ref_mem[addr]);
            chk("rd_last", rd_last, (i == int'(l)));
         end
         @(posedge clk); #1;
         if (!exp_valid) begin
            exp_valid = 1'b1;
         end else if (r) begin
            last = addr; addr = addr + 6'd1; i++; exp_valid = 1'b0;
         end
         cyc++;
      end
      if (cyc >= 300) chk("rd_timeout", 1, 0);
      rd_ready = 1'b0;
      @(negedge clk);
      chk("rd_done_busy", busy, 0);
      chk("rd_done_valid", rd_valid, 0);
      chk("rd_last_addr", last, exp_last);
      @(posedge clk); #1;
   endtask

   vec_t vecs[13];

   initial begin
      logic [5:0] ra;
      logic [3:0] rl;
      int         n0;

      vecs[0]  = '{1'b1, 6'h00, 4'd15, 8'h80, 8'h01, 20, 6'h0F};
      vecs[1]  = '{1'b1, 6'h10, 4'd15, 8'h90, 8'h01, 20, 6'h1F};
      vecs[2]  = '{1'b1, 6'h20, 4'd15, 8'hA0, 8'h01, 20, 6'h2F};
      vecs[3]  = '{1'b1, 6'h30, 4'd15, 8'hB0, 8'h01, 20, 6'h3F};
      vecs[4]  = '{1'b1, 6'h05, 4'd0,  8'hA5, 8'h00, 0,  6'h05};
      vecs[5]  = '{1'b0, 6'h05, 4'd0,  8'h00, 8'h00, 0,  6'h05};
      vecs[6]  = '{1'b1, 6'h3E, 4'd3,  8'h11, 8'h11, 0,  6'h01};
      vecs[7]  = '{1'b0, 6'h3E, 4'd3,  8'h00, 8'h00, 0,  6'h01};
      vecs[8]  = '{1'b1, 6'h0F, 4'd15, 8'h00, 8'h01, 0,  6'h1E};
      vecs[9]  = '{1'b0, 6'h0F, 4'd15, 8'h00, 8'h00, 0,  6'h1E};
      vecs[10] = '{1'b1, 6'h30, 4'd7,  8'h5C, 8'h03, 40, 6'h37};
      vecs[11] = '{1'b0, 6'h30, 4'd7,  8'h00, 8'h00, 50, 6'h37};
      vecs[12] = '{1'b0, 6'h3C, 4'd5,  8'h00, 8'h00, 30, 6'h01};

      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

      // Power-on reset.
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("por");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_reset_outputs("post_rst");
      @(posedge clk); #1;

      // Table: first four rows fill the whole RAM so every later read is defined.
      foreach (vecs[k]) begin
         if (vecs[k].we)
            wr_burst(vecs[k].a, vecs[k].l, vecs[k].d0, vecs[k].dinc, vecs[k].pct,
                     16'h0, 1'b0, vecs[k].exp_last);
         else
            rd_burst(vecs[k].a, vecs[k].l, vecs[k].pct, 0, vecs[k].exp_last);
      end

      // Gappy write: wr_valid 1,0,0,1,1,0,1 gives four writes in seven cycles.
      wr_burst(6'h08, 4'd3, 8'hC1, 8'h07, 0, 16'h0059, 1'b1, 6'h0B);
      // Read with beat 0 held for five cycles before acceptance.
      rd_burst(6'h08, 4'd1, 0, 5, 6'h09);

      // Randomized bursts against the reference model.
      for (int n = 0; n < 24; n++) begin
         ra = 6'($urandom);
         rl = 4'($urandom);
         if ($urandom_range(1) == 1)
            wr_burst(ra, rl, 8'($urandom), 8'($urandom), int'($urandom_range(50)),
                     16'h0, 1'b0, ra + 6'(rl));
         else
            rd_burst(ra, rl, int'($urandom_range(50)), int'($urandom_range(3)), ra + 6'(rl));
      end

      // Reset during beat 2 of an 8-beat write: two beats land, the third never does.
      n0 = nwrites;
      send_cmd(1'b1, 6'h00, 4'd7);
      wr_valid = 1'b1; wr_data = 8'hE0;
      @(posedge clk); #1;
      wr_data = 8'hE1;
      @(posedge clk); #1;
      wr_data = 8'hE2;
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("mid_rst");
      wr_valid = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_writes", nwrites - n0, 2);
      rst_n = 1'b1;
      ref_mem[0] = 8'hE0;
      ref_mem[1] = 8'hE1;
      @(negedge clk);
      chk_reset_outputs("after_rst");
      @(posedge clk); #1;
      rd_burst(6'h00, 4'd2, 0, 0, 6'h02);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
